// File: rtl/fetch_unit.sv
// Instruction-side responder for the multicycle controller: owns PC, IR and STAT,
// resolves sequential/absolute/relative next-PC and freezes fetch on the halt opcode.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              PC_RST,
  input  logic              PC_WRITE,
  input  logic              PC_SEL,
  input  logic              BR_SEL,
  input  logic [DATA_W-1:0] IMEM_DATA,
  input  logic [3:0]        ALU_STAT,
  input  logic              STAT_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [ADDR_W-1:0] PC,
  output logic [3:0]        OPCODE,
  output logic [3:0]        MM,
  output logic [3:0]        STAT,
  output logic              BR_TAKEN,
  output logic              HALTED
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_ir, w_ir_nxt;
  logic [3:0]        r_stat;
  logic              r_br_taken, w_br_nxt;
  logic              r_sel_q;
  logic              w_br_fire;
  logic [15:0]       w_imm;
  logic [ADDR_W-1:0] w_imm_zx, w_imm_sx;
  logic              w_unused_ir;

  assign w_imm    = r_ir[15:0];
  assign w_imm_zx = ADDR_W'(w_imm);
  assign w_imm_sx = ADDR_W'($signed(w_imm));

  // Only the first cycle of a held PC_SEL level counts, and never while halted.
  assign w_br_fire = PC_SEL & ~r_sel_q & (r_state == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_br_nxt    = 1'b0;
    if (PC_RST) begin
      w_state_nxt = S_RUN;
      w_pc_nxt    = '0;
      w_ir_nxt    = '0;
    end else if (r_state == S_RUN) begin
      if (w_br_fire) begin
        w_br_nxt = 1'b1;
        w_pc_nxt = BR_SEL ? w_imm_zx : (r_pc + w_imm_sx);
      end else if (PC_WRITE) begin
        w_ir_nxt = IMEM_DATA;
        w_pc_nxt = r_pc + ADDR_W'(1);
        if (IMEM_DATA[DATA_W-1 -: 4] == HALT_OP) begin
          w_state_nxt = S_HALT;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_F) begin
      r_state    <= S_RUN;
      r_pc       <= '0;
      r_ir       <= '0;
      r_stat     <= '0;
      r_br_taken <= 1'b0;
      r_sel_q    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_br_taken <= w_br_nxt;
      r_sel_q    <= PC_RST ? 1'b0 : PC_SEL;
      // STAT keeps tracking the ALU in HALT and survives PC_RST.
      if (STAT_WE) begin
        r_stat <= ALU_STAT;
      end
    end
  end

  assign w_unused_ir = ^r_ir[DATA_W-9:16];

  assign IMEM_ADDR = r_pc;
  assign PC        = r_pc;
  assign OPCODE    = r_ir[DATA_W-1 -: 4];
  assign MM        = r_ir[DATA_W-5 -: 4];
  assign STAT      = r_stat;
  assign BR_TAKEN  = r_br_taken;
  assign HALTED    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each scenario task drives a step table, queues the
// expected outputs and compares them one cycle later against a combinational IMEM model.
module tb_fetch_unit;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              CLK;
  logic              RST_F;
  logic              PC_RST;
  logic              PC_WRITE;
  logic              PC_SEL;
  logic              BR_SEL;
  logic [DATA_W-1:0] IMEM_DATA;
  logic [3:0]        ALU_STAT;
  logic              STAT_WE;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [ADDR_W-1:0] PC;
  logic [3:0]        OPCODE;
  logic [3:0]        MM;
  logic [3:0]        STAT;
  logic              BR_TAKEN;
  logic              HALTED;

  logic [31:0] imem [0:65535];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [45:0] exp_q [$];
  string       tag_q [$];

  typedef struct packed {
    logic        rst_f;
    logic        pc_rst;
    logic        pw;
    logic        ps;
    logic        bs;
    logic        we;
    logic [3:0]  alu;
    logic [15:0] pc;
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [3:0]  st;
    logic        br;
    logic        h;
  } step_t;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_OP(4'hF)) dut (
    .CLK(CLK), .RST_F(RST_F), .PC_RST(PC_RST), .PC_WRITE(PC_WRITE),
    .PC_SEL(PC_SEL), .BR_SEL(BR_SEL), .IMEM_DATA(IMEM_DATA), .ALU_STAT(ALU_STAT),
    .STAT_WE(STAT_WE), .IMEM_ADDR(IMEM_ADDR), .PC(PC), .OPCODE(OPCODE), .MM(MM),
    .STAT(STAT), .BR_TAKEN(BR_TAKEN), .HALTED(HALTED)
  );

  assign IMEM_DATA = imem[IMEM_ADDR];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(input int rst_f, input int pc_rst, input int pw, input int ps,
                               input int bs, input int we, input int alu, input int pc,
                               input int op, input int mm, input int st, input int br,
                               input int h);
    step_t s;
    s.rst_f  = 1'(rst_f);
    s.pc_rst = 1'(pc_rst);
    s.pw     = 1'(pw);
    s.ps     = 1'(ps);
    s.bs     = 1'(bs);
    s.we     = 1'(we);
    s.alu    = 4'(alu);
    s.pc     = 16'(pc);
    s.op     = 4'(op);
    s.mm     = 4'(mm);
    s.st     = 4'(st);
    s.br     = 1'(br);
    s.h      = 1'(h);
    return s;
  endfunction

  function automatic logic [45:0] expv(input step_t s);
    return {s.pc, s.pc, s.op, s.mm, s.st, s.br, s.h};
  endfunction

  function automatic logic [45:0] obs();
    return {IMEM_ADDR, PC, OPCODE, MM, STAT, BR_TAKEN, HALTED};
  endfunction

  task automatic apply(input step_t s);
    RST_F    = s.rst_f;
    PC_RST   = s.pc_rst;
    PC_WRITE = s.pw;
    PC_SEL   = s.ps;
    BR_SEL   = s.bs;
    STAT_WE  = s.we;
    ALU_STAT = s.alu;
  endtask

  task automatic test_reset();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(0,0,0,0,0,0,0, 16'h0000, 0,0,0,0,0));
    s.push_back(mk(0,0,1,1,1,1,9, 16'h0000, 0,0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("reset[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  task automatic test_seq_fetch();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0001, 8,1,0,0,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0002, 0,0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("seq_fetch[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  task automatic test_abs_branch();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0003, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h0004, 4,0,0,1,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0005, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h0020, 4,0,0,1,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h0020, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h0020, 4,0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("abs_branch[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  task automatic test_collision();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0021, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h0006, 4,0,0,1,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0007, 4,0,0,0,0));
    s.push_back(mk(1,0,1,1,1,0,0, 16'h0040, 4,0,0,1,0));
    s.push_back(mk(1,0,0,0,0,0,0, 16'h0040, 4,0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("collision[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  task automatic test_rel_branch();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0041, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h000F, 4,0,0,1,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0010, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,0,0,0, 16'h000C, 4,0,0,1,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("rel_branch[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(1,0,1,0,0,0,0, 16'h000D, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'hFFFD, 4,0,0,1,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'hFFFE, 4,0,0,0,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'hFFFF, 4,0,0,0,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0000, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'hFFFD, 4,0,0,1,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'hFFFE, 4,0,0,0,0));
    s.push_back(mk(1,0,0,1,0,0,0, 16'h0001, 4,0,0,1,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("wrap[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  task automatic test_stat_halt();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(1,0,0,0,0,1,4'hA, 16'h0001, 4,0,4'hA,0,0));
    s.push_back(mk(1,0,0,1,1,0,0,    16'h0003, 4,0,4'hA,1,0));
    s.push_back(mk(1,0,1,0,0,0,0,    16'h0004, 4'hF,0,4'hA,0,1));
    s.push_back(mk(1,0,1,0,0,0,0,    16'h0004, 4'hF,0,4'hA,0,1));
    s.push_back(mk(1,0,0,1,1,0,0,    16'h0004, 4'hF,0,4'hA,0,1));
    s.push_back(mk(1,0,1,1,1,1,4'h5, 16'h0004, 4'hF,0,4'h5,0,1));
    s.push_back(mk(1,1,0,0,0,0,0,    16'h0000, 0,0,4'h5,0,0));
    s.push_back(mk(1,0,1,0,0,0,0,    16'h0001, 8,1,4'h5,0,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("stat_halt[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_branch();
    step_t s [$];
    logic [45:0] got, want;
    string tag;
    s.push_back(mk(0,0,0,1,1,0,0, 16'h0000, 0,0,0,0,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h0000, 0,0,0,1,0));
    s.push_back(mk(1,0,0,1,1,0,0, 16'h0000, 0,0,0,0,0));
    s.push_back(mk(1,0,1,0,0,0,0, 16'h0001, 8,1,0,0,0));
    s.push_back(mk(0,0,0,0,0,0,0, 16'h0000, 0,0,0,0,0));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(expv(s[i]));
      tag_q.push_back($sformatf("reset_mid_branch[%0d]", i));
      @(posedge CLK); #1;
      got = obs(); want = exp_q.pop_front(); tag = tag_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h (addr,pc,op,mm,stat,br,halt)", tag, got, want);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = 32'h0;
    imem[16'h0000] = 32'h8100_0005;
    imem[16'h0001] = 32'h0000_0000;
    imem[16'h0002] = 32'h4000_0004;
    imem[16'h0003] = 32'hF000_0000;
    imem[16'h0004] = 32'h4000_0020;
    imem[16'h0006] = 32'h4000_0040;
    imem[16'h0007] = 32'h9300_0000;
    imem[16'h000C] = 32'h4000_FFFD;
    imem[16'h000F] = 32'h4000_FFFC;
    imem[16'h0020] = 32'h4000_0006;
    imem[16'h0040] = 32'h4000_000F;
    imem[16'hFFFD] = 32'h4000_0003;
    imem[16'hFFFE] = 32'h4000_0000;
    imem[16'hFFFF] = 32'h4000_FFFD;

    RST_F    = 1'b0;
    PC_RST   = 1'b0;
    PC_WRITE = 1'b0;
    PC_SEL   = 1'b0;
    BR_SEL   = 1'b0;
    STAT_WE  = 1'b0;
    ALU_STAT = 4'h0;

    test_reset();
    test_seq_fetch();
    test_abs_branch();
    test_collision();
    test_rel_branch();
    test_wrap();
    test_stat_halt();
    test_reset_mid_branch();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_drain got=%0d want=0 leftover entries", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
